// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop based counter blocks.
package jk_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Clamp a parallel-load value into the legal count range 0..modulo-1.
    function automatic int unsigned sat_load(input int unsigned val, input int unsigned modulo);
        return (val < modulo) ? val : modulo - 1;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with asynchronous active-low reset.
module jk_ff (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    // Classic JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from toggle-driven JK flip-flops.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ZERO_CNT = '0;
    localparam logic [WIDTH-1:0] ONE_CNT  = WIDTH'(1);

    // Reject a modulo that does not fit the counter width.
    generate
        if ((MODULO < 2) || (MODULO > (2 ** WIDTH))) begin : gBadModulo
            $error("jk_mod_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] loadSat;
    logic [WIDTH-1:0] jkToggle;
    logic [WIDTH-1:0] unusedQbar;
    logic             wrap_d;
    logic             wrap_q;

    assign loadSat = WIDTH'(sat_load(32'(load_val), MODULO));

    // Next count and wrap flag: load beats enable, enable beats hold.
    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = loadSat;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (count == MAX_CNT) begin
                    count_d = ZERO_CNT;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count + ONE_CNT;
                end
            end else begin
                if (count == ZERO_CNT) begin
                    count_d = MAX_CNT;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count - ONE_CNT;
                end
            end
        end
    end

    // Each bit flips only where the next count differs, so J and K are always equal.
    assign jkToggle = count_d ^ count;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : gBit
            jk_ff uBit (
                .clk   (clk),
                .reset (reset),
                .j     (jkToggle[i]),
                .k     (jkToggle[i]),
                .q     (count[i]),
                .q_bar (unusedQbar[i])
            );
        end
    endgenerate

    // One-cycle wrap pulse, recomputed every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

    assign tc = en & ~load & (((up_dn == DIR_UP) & (count == MAX_CNT)) |
                              ((up_dn == DIR_DN) & (count == ZERO_CNT)));

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter. Each state bit is one instance of the team's existing JK flip-flop (jk_ff), driven in toggle form.
- Downstream consumer of jk_ff; it turns J/K cells into a usable count and event source.
- Typical uses: cycle dividers, timeout counters, stimulus sequencing in flip-flop demo designs.

Parameters:
- WIDTH, 4, number of count bits (one jk_ff per bit).
- MODULO, 10, count range is 0..MODULO-1. Legal values are 2 <= MODULO <= 2**WIDTH; other values are rejected by an elaboration-time check.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- count  output  WIDTH  current count (the jk_ff q outputs).
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- Reset (reset=0): count=0 and wrap=0 immediately, without waiting for clk. Held while reset=0.
- Reset release: the first rising clk edge after reset=1 may update state.
- Reset asserted mid-count overrides everything, including a load in the same cycle.
- Priority at each rising edge: load > en > hold.
- load=1:
  - count <= load_val if load_val < MODULO, else count <= MODULO-1 (saturating).
  - wrap <= 0.
  - en and up_dn are ignored.
- en=1, load=0, up_dn=1: count <= count+1. At count==MODULO-1, count <= 0 and wrap <= 1.
- en=1, load=0, up_dn=0: count <= count-1. At count==0, count <= MODULO-1 and wrap <= 1.
- en=0, load=0: count holds; wrap <= 0.
- wrap is high for exactly one cycle per wrap. Two consecutive wraps give two separate pulses, because wrap is recomputed every cycle.
- tc = en & ~load & ((up_dn & count==MODULO-1) | (~up_dn & count==0)).
  - Purely combinational; no latency.
  - Intended as a cascade enable for the next counter stage.
- Latency: count reflects load/en on the same edge they are sampled; wrap rises on that same edge.
- Bit mapping:
  - next_count is computed combinationally.
  - For bit i: j[i] = k[i] = next_count[i] ^ count[i] (toggle form).
  - jk_ff never sees J=1,K=0 or J=0,K=1 from this block.
- Width rules: the +1/-1 arithmetic is WIDTH bits wide. No result outside 0..MODULO-1 is ever stored. When MODULO = 2**WIDTH, natural binary wrap applies.
- Direction change mid-count takes effect on the next enabled edge; there is no glitch state.

Decomposition:
- Shared package jk_pkg:
  - localparam DIR_UP=1'b1, DIR_DN=1'b0.
  - Function sat_load(val, modulo) for the load clamp, reused by other JK-based blocks.
- Sub-module: jk_ff (existing). WIDTH instances, generate loop, ports (clk, reset, j, k, q, q_bar). q_bar is left unused.
- Count next-state logic and the wrap register live in jk_mod_counter itself.

Test Plan (WIDTH=4, MODULO=10):
- Assert reset=0 for 3 time units with clk idle, then release → count=0 and wrap=0 before any clk edge.
- en=1, up_dn=1, 12 edges from 0 → count 1..9,0,1,2. wrap high for one cycle only after the 9→0 edge. tc=1 while count=9.
- en=1, up_dn=0 from 2, 4 edges → count 1,0,9,8. wrap pulses after the 0→9 edge. tc=1 while count=0.
- load=1, load_val=4'd7 with en=1 → count=7 next edge. Then load_val=4'd13 → count=9 (saturate). tc stays 0 while load=1.
- Count up to 5, drop en for 3 cycles, then flip up_dn=0 and re-enable → count holds 5, then 4,3. No wrap pulse.
- Drive reset=0 mid-count at count=6, between clk edges, with load=1 pending → count=0 asynchronously. After release, first edge performs the load.
